// File: rtl/ahb_dma_ctrl_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_dma_ctrl_regs_if
// Purpose  : AHB-Lite slave-side bus bundle for the DMA/NPU channel register
//            file. The master modport drives the address/data phase signals
//            and the slave modport returns read data, ready and response.
// Ports    : hsel, hwrite, hready_in, htrans[1:0], hsize[2:0],
//            haddr[ADDR_W-1:0], hwdata[31:0]     (master -> slave)
//            hrdata[31:0], hready_out, hresp[1:0] (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_dma_ctrl_regs_if #(
  parameter int ADDR_W = 12
);
  logic              hsel;
  logic              hwrite;
  logic              hready_in;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [ADDR_W-1:0] haddr;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready_out;
  logic [1:0]        hresp;

  modport master (
    output hsel, hwrite, hready_in, htrans, hsize, haddr, hwdata,
    input  hrdata, hready_out, hresp
  );

  modport slave (
    input  hsel, hwrite, hready_in, htrans, hsize, haddr, hwdata,
    output hrdata, hready_out, hresp
  );
endinterface
`default_nettype wire

// File: rtl/ahb_dma_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : ahb_dma_ctrl_regs
// Purpose  : AHB-Lite register file controlling NUM_CH DMA/NPU channels.
//            Each channel has CTRL/SRC/DST/BLK/STAT/IE registers, an
//            IDLE/BUSY state machine with registered start/stop pulses,
//            automatic source/destination address advance, sticky W1C done
//            status and a combined level interrupt. Illegal accesses get a
//            two-cycle ERROR response when ERR_EN = 1.
// Ports    : hclk, hreset (async, active-low)
//            bus          - ahb_dma_ctrl_regs_if.slave
//            ch_start     - [NUM_CH]        start pulse per channel
//            ch_stop      - [NUM_CH]        abort pulse per channel
//            ch_src/dst   - [32*NUM_CH]     current addresses
//            ch_blk       - [BLK_W*NUM_CH]  block size in words
//            ch_rd_update, ch_wr_update, ch_done - [NUM_CH] datapath pulses
//            irq          - combined interrupt (level)
// Revision : 1.0 - initial release
// ============================================================================
module ahb_dma_ctrl_regs #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 12,
  parameter int BLK_W  = 5,
  parameter int ERR_EN = 1
) (
  input  wire logic                    hclk,
  input  wire logic                    hreset,
  ahb_dma_ctrl_regs_if.slave           bus,
  output logic [NUM_CH-1:0]            ch_start,
  output logic [NUM_CH-1:0]            ch_stop,
  output logic [32*NUM_CH-1:0]         ch_src,
  output logic [32*NUM_CH-1:0]         ch_dst,
  output logic [BLK_W*NUM_CH-1:0]      ch_blk,
  input  wire logic [NUM_CH-1:0]       ch_rd_update,
  input  wire logic [NUM_CH-1:0]       ch_wr_update,
  input  wire logic [NUM_CH-1:0]       ch_done,
  output logic                         irq
);

  localparam logic [2:0]  c_size_word = 3'b010;
  localparam logic [31:0] c_version   = 32'h0002_0000 | 32'(NUM_CH);
  localparam logic        c_err_en    = (ERR_EN != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ch_state_t;

  // --------------------------------------------------------------------------
  // Address phase decode
  // --------------------------------------------------------------------------
  logic       w_accept;
  logic       w_legal;
  logic       w_glob;
  logic [2:0] w_ch;
  logic [2:0] w_off;
  logic       w_unused_ok;

  assign w_accept    = bus.hsel & bus.htrans[1] & bus.hready_in & bus.hready_out;
  assign w_glob      = bus.haddr[8];
  assign w_ch        = bus.haddr[7:5];
  assign w_off       = bus.haddr[4:2];
  assign w_unused_ok = bus.htrans[0];

  always_comb begin
    w_legal = 1'b0;
    if ((bus.hsize == c_size_word) && (bus.haddr[1:0] == 2'b00) &&
        (bus.haddr[ADDR_W-1:9] == '0)) begin
      if (w_glob) begin
        // Only 0x100 (IRQ_STAT) and 0x104 (VERSION) exist in the global page.
        w_legal = (bus.haddr[7:3] == 5'b0);
      end else begin
        w_legal = (int'(w_ch) < NUM_CH) && (w_off <= 3'd5);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data phase bookkeeping and error response
  // --------------------------------------------------------------------------
  logic       r_dphase;
  logic       r_write;
  logic       r_legal;
  logic       r_glob;
  logic [2:0] r_ch;
  logic [2:0] r_off;
  logic       r_err1;
  logic       r_err2;

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      r_dphase <= 1'b0;
      r_write  <= 1'b0;
      r_legal  <= 1'b0;
      r_glob   <= 1'b0;
      r_ch     <= 3'd0;
      r_off    <= 3'd0;
      r_err1   <= 1'b0;
      r_err2   <= 1'b0;
    end else begin
      r_dphase <= w_accept;
      r_err1   <= w_accept & ~w_legal & c_err_en;
      r_err2   <= r_err1;
      if (w_accept) begin
        r_write <= bus.hwrite;
        r_legal <= w_legal;
        r_glob  <= w_glob;
        r_ch    <= w_ch;
        r_off   <= w_off;
      end
    end
  end

  // The first ERROR cycle stalls the bus; the second completes it.
  assign bus.hready_out = ~r_err1;
  assign bus.hresp      = {1'b0, r_err1 | r_err2};

  logic w_wr;
  logic w_rd;
  assign w_wr = r_dphase & r_write & r_legal & ~r_glob;
  assign w_rd = r_dphase & ~r_write & r_legal;

  // --------------------------------------------------------------------------
  // Per-channel registers and state machines
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0]    w_done;
  logic [NUM_CH-1:0]    w_ie;
  logic [32*NUM_CH-1:0] w_rdata_flat;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_t      r_state;
    ch_state_t      w_state_nxt;
    logic           r_start;
    logic           r_stop;
    logic           w_start_nxt;
    logic           w_stop_nxt;
    logic [31:0]    r_src;
    logic [31:0]    r_dst;
    logic [BLK_W-1:0] r_blk;
    logic           r_stride;
    logic           r_done;
    logic           r_ie;
    logic           w_sel;
    logic           w_wr_ctrl;
    logic           w_wr_src;
    logic           w_wr_dst;
    logic           w_wr_blk;
    logic           w_wr_stat;
    logic           w_wr_ie;
    logic           w_start_req;
    logic           w_stop_req;
    logic [31:0]    w_rdata;

    assign w_sel       = w_wr && (r_ch == 3'(g));
    assign w_wr_ctrl   = w_sel && (r_off == 3'd0);
    assign w_wr_src    = w_sel && (r_off == 3'd1);
    assign w_wr_dst    = w_sel && (r_off == 3'd2);
    assign w_wr_blk    = w_sel && (r_off == 3'd3);
    assign w_wr_stat   = w_sel && (r_off == 3'd4);
    assign w_wr_ie     = w_sel && (r_off == 3'd5);
    assign w_start_req = w_wr_ctrl & bus.hwdata[0];
    assign w_stop_req  = w_wr_ctrl & bus.hwdata[1];

    // STOP is checked first so a combined START|STOP write only aborts.
    always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = 1'b0;
      w_stop_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_stop_req) begin
            w_stop_nxt = 1'b1;
          end else if (w_start_req) begin
            w_start_nxt = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_stop_req) begin
            w_stop_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (ch_done[g]) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
        r_state <= ST_IDLE;
        r_start <= 1'b0;
        r_stop  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_start <= w_start_nxt;
        r_stop  <= w_stop_nxt;
      end
    end

    // Bus writes to SRC/DST take precedence over same-cycle update pulses;
    // a done pulse beats a same-cycle W1C so completion is never lost.
    always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
        r_src    <= 32'd0;
        r_dst    <= 32'd0;
        r_blk    <= '0;
        r_stride <= 1'b0;
        r_done   <= 1'b0;
        r_ie     <= 1'b1;
      end else begin
        if (w_wr_src) begin
          r_src <= bus.hwdata;
        end else if (ch_rd_update[g]) begin
          r_src <= r_src + (32'(r_blk) << 2);
        end
        if (w_wr_dst) begin
          r_dst <= bus.hwdata;
        end else if (ch_wr_update[g]) begin
          r_dst <= r_dst + (r_stride ? 32'd32 : 32'd4);
        end
        if (w_wr_blk) begin
          r_blk <= bus.hwdata[BLK_W-1:0];
        end
        if (w_wr_ctrl) begin
          r_stride <= bus.hwdata[3];
        end
        r_done <= ch_done[g] | (r_done & ~(w_wr_stat & bus.hwdata[0]));
        if (w_wr_ie) begin
          r_ie <= bus.hwdata[0];
        end
      end
    end

    always_comb begin
      w_rdata = 32'd0;
      case (r_off)
        3'd0:    w_rdata = {28'd0, r_stride, (r_state == ST_BUSY), 2'b00};
        3'd1:    w_rdata = r_src;
        3'd2:    w_rdata = r_dst;
        3'd3:    w_rdata = 32'(r_blk);
        3'd4:    w_rdata = {31'd0, r_done};
        3'd5:    w_rdata = {31'd0, r_ie};
        default: w_rdata = 32'd0;
      endcase
    end

    assign w_rdata_flat[32*g +: 32]   = w_rdata;
    assign w_done[g]                  = r_done;
    assign w_ie[g]                    = r_ie;
    assign ch_start[g]                = r_start;
    assign ch_stop[g]                 = r_stop;
    assign ch_src[32*g +: 32]         = r_src;
    assign ch_dst[32*g +: 32]         = r_dst;
    assign ch_blk[BLK_W*g +: BLK_W]   = r_blk;
  end

  // --------------------------------------------------------------------------
  // Read data: only driven during a legal read data phase, else zero.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.hrdata = 32'd0;
    if (w_rd) begin
      if (r_glob) begin
        bus.hrdata = r_off[0] ? c_version : 32'(w_done & w_ie);
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (r_ch == 3'(c)) begin
            bus.hrdata = w_rdata_flat[32*c +: 32];
          end
        end
      end
    end
  end

  assign irq = |(w_done & w_ie);

endmodule
`default_nettype wire

// File: tb/tb_ahb_dma_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_dma_ctrl_regs
// Purpose  : Directed self-checking bench. Two instances share one bus
//            stimulus: u_dut1 (ERR_EN = 1) and u_dut0 (ERR_EN = 0); each
//            instance's hready_in is its own hready_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_dma_ctrl_regs;

  logic        hclk = 1'b0;
  logic        hreset = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [11:0] haddr = 12'h000;
  logic [31:0] hwdata = 32'd0;
  logic [1:0]  ch_rd_update = 2'b00, ch_wr_update = 2'b00, ch_done = 2'b00;

  logic [1:0]  ch_start1, ch_stop1, ch_start0, ch_stop0;
  logic [63:0] ch_src1, ch_dst1, ch_src0, ch_dst0;
  logic [9:0]  ch_blk1, ch_blk0;
  logic        irq1, irq0;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_dma_ctrl_regs_if #(.ADDR_W(12)) b1 ();
  ahb_dma_ctrl_regs_if #(.ADDR_W(12)) b0 ();

  assign b1.hsel = hsel;   assign b0.hsel = hsel;
  assign b1.hwrite = hwrite; assign b0.hwrite = hwrite;
  assign b1.htrans = htrans; assign b0.htrans = htrans;
  assign b1.hsize = hsize; assign b0.hsize = hsize;
  assign b1.haddr = haddr; assign b0.haddr = haddr;
  assign b1.hwdata = hwdata; assign b0.hwdata = hwdata;
  assign b1.hready_in = b1.hready_out;
  assign b0.hready_in = b0.hready_out;

  ahb_dma_ctrl_regs #(.NUM_CH(2), .ADDR_W(12), .BLK_W(5), .ERR_EN(1)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .bus(b1),
    .ch_start(ch_start1), .ch_stop(ch_stop1),
    .ch_src(ch_src1), .ch_dst(ch_dst1), .ch_blk(ch_blk1),
    .ch_rd_update(ch_rd_update), .ch_wr_update(ch_wr_update),
    .ch_done(ch_done), .irq(irq1)
  );

  ahb_dma_ctrl_regs #(.NUM_CH(2), .ADDR_W(12), .BLK_W(5), .ERR_EN(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .bus(b0),
    .ch_start(ch_start0), .ch_stop(ch_stop0),
    .ch_src(ch_src0), .ch_dst(ch_dst0), .ch_blk(ch_blk0),
    .ch_rd_update(ch_rd_update), .ch_wr_update(ch_wr_update),
    .ch_done(ch_done), .irq(irq0)
  );

  // Values captured by xfer during the data phase.
  logic [31:0] rd1, rd1_b, rd0;
  logic        rdy1_a, rdy1_b, rdy0;
  logic [1:0]  rsp1_a, rsp1_b, rsp0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge. dn/rdu are driven during the
  // data phase so they coincide with the register write.
  task automatic xfer(input logic wr, input logic [11:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [1:0] dn, input logic [1:0] rdu);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
    hwdata = wr ? wd : 32'd0;
    ch_done = dn; ch_rd_update = rdu;
    @(negedge hclk);
    rd1 = b1.hrdata; rd0 = b0.hrdata;
    rdy1_a = b1.hready_out; rsp1_a = b1.hresp;
    rdy0 = b0.hready_out; rsp0 = b0.hresp;
    rd1_b = rd1; rdy1_b = rdy1_a; rsp1_b = rsp1_a;
    if (!rdy1_a) begin
      @(posedge hclk); #1;
      @(negedge hclk);
      rdy1_b = b1.hready_out; rsp1_b = b1.hresp; rd1_b = b1.hrdata;
    end
    @(posedge hclk); #1;
    ch_done = 2'b00; ch_rd_update = 2'b00; hwdata = 32'd0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    xfer(1'b1, a, 3'b010, d, 2'b00, 2'b00);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    xfer(1'b0, a, 3'b010, 32'd0, 2'b00, 2'b00);
    d = rd1;
  endtask

  task automatic next_cycle;
    @(posedge hclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;

    // ---------------- Reset values ----------------
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b1;
    next_cycle();
    @(negedge hclk);
    chk("rst_hready", {31'd0, b1.hready_out}, 32'd1);
    chk("rst_hresp", {30'd0, b1.hresp}, 32'd0);
    chk("rst_hrdata", b1.hrdata, 32'd0);
    chk("rst_irq", {31'd0, irq1}, 32'd0);
    chk("rst_start_stop", {28'd0, ch_start1, ch_stop1}, 32'd0);
    chk("rst_src_dst_blk", ch_src1[31:0] | ch_src1[63:32] | ch_dst1[31:0] |
        ch_dst1[63:32] | {22'd0, ch_blk1}, 32'd0);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      for (int o = 0; o < 6; o++) begin
        rd(12'(c * 32 + o * 4), d);
        chk($sformatf("rst_ch%0d_off%0d", c, o * 4), d, (o == 5) ? 32'd1 : 32'd0);
      end
    end
    rd(12'h104, d);
    chk("rst_version", d, 32'h0002_0002);
    chk("rst_version_e0", rd0, 32'h0002_0002);
    rd(12'h100, d);
    chk("rst_irq_stat", d, 32'd0);

    // ---------------- Start and done ----------------
    wr(12'h024, 32'h0000_1000);
    wr(12'h02C, 32'd4);
    wr(12'h020, 32'h1);
    @(negedge hclk);
    chk("start_pulse", {30'd0, ch_start1}, 32'd2);
    next_cycle();
    @(negedge hclk);
    chk("start_pulse_end", {30'd0, ch_start1}, 32'd0);
    next_cycle();
    rd(12'h020, d);
    chk("busy_read", d, 32'h4);
    ch_rd_update = 2'b10; next_cycle(); ch_rd_update = 2'b00; next_cycle();
    ch_rd_update = 2'b10; next_cycle(); ch_rd_update = 2'b00;
    @(negedge hclk);
    chk("src_port_after_upd", ch_src1[63:32], 32'h0000_1020);
    next_cycle();
    rd(12'h024, d);
    chk("src_read_after_upd", d, 32'h0000_1020);
    ch_done = 2'b10;
    @(negedge hclk);
    chk("irq_before_done_edge", {31'd0, irq1}, 32'd0);
    next_cycle();
    ch_done = 2'b00;
    @(negedge hclk);
    chk("irq_after_done", {31'd0, irq1}, 32'd1);
    next_cycle();
    rd(12'h030, d);
    chk("done_set", d, 32'd1);
    rd(12'h020, d);
    chk("idle_after_done", d, 32'd0);
    rd(12'h100, d);
    chk("irq_stat", d, 32'h2);
    wr(12'h030, 32'h1);
    @(negedge hclk);
    chk("irq_after_w1c", {31'd0, irq1}, 32'd0);
    next_cycle();

    // ---------------- Stride and wrap-around ----------------
    wr(12'h028, 32'hFFFF_FFF0);
    wr(12'h020, 32'h8);
    rd(12'h020, d);
    chk("stride_ctrl_read", d, 32'h8);
    ch_wr_update = 2'b10; next_cycle(); ch_wr_update = 2'b00;
    @(negedge hclk);
    chk("dst_stride32_wrap", ch_dst1[63:32], 32'h0000_0010);
    next_cycle();
    wr(12'h028, 32'hFFFF_FFF0);
    wr(12'h020, 32'h0);
    ch_wr_update = 2'b10; next_cycle(); ch_wr_update = 2'b00;
    @(negedge hclk);
    chk("dst_stride4", ch_dst1[63:32], 32'hFFFF_FFF4);
    next_cycle();

    // ---------------- Simultaneous events ----------------
    xfer(1'b1, 12'h030, 3'b010, 32'h1, 2'b10, 2'b00);
    rd(12'h030, d);
    chk("done_set_beats_w1c", d, 32'd1);
    wr(12'h030, 32'h1);
    rd(12'h030, d);
    chk("done_cleared", d, 32'd0);
    xfer(1'b1, 12'h024, 3'b010, 32'h55, 2'b00, 2'b10);
    rd(12'h024, d);
    chk("src_write_beats_upd", d, 32'h55);
    wr(12'h020, 32'h1);
    next_cycle();
    wr(12'h020, 32'h1);
    @(negedge hclk);
    chk("no_start_while_busy", {30'd0, ch_start1}, 32'd0);
    next_cycle();
    rd(12'h020, d);
    chk("still_busy", d, 32'h4);

    // ---------------- Errors ----------------
    xfer(1'b0, 12'h040, 3'b010, 32'd0, 2'b00, 2'b00);
    chk("err_rd_c1_ready", {31'd0, rdy1_a}, 32'd0);
    chk("err_rd_c1_resp", {30'd0, rsp1_a}, 32'd1);
    chk("err_rd_c2_ready", {31'd0, rdy1_b}, 32'd1);
    chk("err_rd_c2_resp", {30'd0, rsp1_b}, 32'd1);
    chk("err_rd_data", rd1 | rd1_b, 32'd0);
    chk("e0_rd_ready_resp", {29'd0, rdy0, rsp0}, 32'h4);
    chk("e0_rd_data", rd0, 32'd0);
    xfer(1'b1, 12'h024, 3'b001, 32'h0000_DEAD, 2'b00, 2'b00);
    chk("err_hw_resp", {29'd0, rdy1_a, rsp1_a}, 32'h1);
    chk("e0_hw_okay", {29'd0, rdy0, rsp0}, 32'h4);
    rd(12'h024, d);
    chk("err_hw_src_kept", d, 32'h55);
    chk("e0_hw_src_kept", rd0, 32'h55);

    // ---------------- Stop ----------------
    wr(12'h020, 32'h2);
    @(negedge hclk);
    chk("stop_pulse", {30'd0, ch_stop1}, 32'd2);
    next_cycle();
    @(negedge hclk);
    chk("stop_pulse_end", {30'd0, ch_stop1}, 32'd0);
    next_cycle();
    rd(12'h020, d);
    chk("idle_after_stop", d, 32'd0);
    rd(12'h030, d);
    chk("no_done_after_stop", d, 32'd0);
    rd(12'h024, d);
    chk("src_kept_after_stop", d, 32'h55);
    wr(12'h020, 32'h3);
    @(negedge hclk);
    chk("start_stop_both", {28'd0, ch_start1, ch_stop1}, 32'h2);
    next_cycle();
    rd(12'h020, d);
    chk("idle_after_both", d, 32'd0);

    // ---------------- Reset during a write data phase ----------------
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 12'h024; hsize = 3'b010;
    next_cycle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0000_ABCD;
    #2 hreset = 1'b0;
    next_cycle();
    @(negedge hclk);
    chk("midrst_src_port", ch_src1[63:32], 32'd0);
    chk("midrst_ready_resp", {29'd0, b1.hready_out, b1.hresp}, 32'h4);
    chk("midrst_irq", {31'd0, irq1}, 32'd0);
    next_cycle();
    hreset = 1'b1; hwdata = 32'd0;
    next_cycle();
    rd(12'h024, d);
    chk("midrst_src_read", d, 32'd0);
    rd(12'h034, d);
    chk("midrst_ie", d, 32'd1);
    rd(12'h02C, d);
    chk("midrst_blk", d, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_dma_ctrl_regs.md
# ahb_dma_ctrl_regs

Parametrised AHB-Lite slave register file that controls NUM_CH independent DMA/NPU channels. It replaces the single-channel control block that sits between the AHB interconnect and the DMA/NPU datapath. Over the single-channel version it adds per-channel start/stop/busy/done handshakes, sticky W1C done status with a combined interrupt, a configurable destination stride, and AHB ERROR responses for illegal accesses.

## Interface
Parameters:
- NUM_CH, 2: number of channels (1..4).
- ADDR_W, 12: decoded haddr bits.
- BLK_W, 5: block-size field width (1..16).
- ERR_EN, 1: when 1, illegal accesses get an ERROR response; when 0, they are ignored with OKAY.

Ports:
- hclk  in  1  clock.
- hreset  in  1  reset, asynchronous, active-low.
- hsel, hwrite, hready_in  in  1  AHB select, direction, bus ready.
- htrans  in  2  AHB transfer type; bit1 = NONSEQ/SEQ.
- hsize  in  3  transfer size; only 3'b010 (word) is legal.
- haddr  in  ADDR_W  byte address.
- hwdata  in  32  write data (valid in the data phase).
- hrdata  out  32  read data.
- hready_out  out  1  slave ready.
- hresp  out  2  00 = OKAY, 01 = ERROR.
- ch_start  out  NUM_CH  one-cycle start pulse per channel.
- ch_stop  out  NUM_CH  one-cycle abort pulse per channel.
- ch_src, ch_dst  out  32*NUM_CH  current source and destination addresses; channel c occupies bits [32c+31:32c].
- ch_blk  out  BLK_W*NUM_CH  block size, in words.
- ch_rd_update, ch_wr_update  in  NUM_CH  one-cycle pulses: a block has been read / a word burst has been written.
- ch_done  in  NUM_CH  one-cycle completion pulse.
- irq  out  1  combined interrupt, level.

## Operation
Address map (word offsets; channel c base = c*0x20):
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 STOP (write-1 pulse, reads 0), bit2 BUSY (read-only), bit3 STRIDE.
- 0x04 SRC, 0x08 DST: read/write, 32 bits.
- 0x0C BLK: bits [BLK_W-1:0].
- 0x10 STAT: bit0 DONE, sticky, write-1-to-clear.
- 0x14 IE: bit0 interrupt enable.
- Global 0x100 IRQ_STAT: bits [NUM_CH-1:0] = DONE & IE, read-only.
- Global 0x104 VERSION: reads 32'h0002_0000 | NUM_CH.
- Illegal access: a channel index >= NUM_CH, an unlisted offset, or hsize != 010.

Address phase and data phase:
- An address phase is accepted when hsel & htrans[1] & hready_in & hready_out.
- Accepting it latches the address, hwrite and a legal/illegal flag.
- Writes take effect at the end of the data phase, using hwdata.
- Reads: hrdata is combinational from the latched address during the data phase and 0 at all other times. Reserved bits read 0.

Channel state machine, per channel: IDLE -> BUSY -> IDLE.
- IDLE -> BUSY: START written while IDLE. ch_start pulses for one cycle on the clock after the data phase.
- START written while BUSY is ignored: no pulse, no state change.
- BUSY -> IDLE on ch_done. ch_done also sets DONE.
- BUSY -> IDLE on a STOP write. ch_stop pulses for one cycle. DONE is not set. SRC, DST and BLK are retained.
- STOP written while IDLE: ch_stop still pulses; state stays IDLE.

Address update arithmetic (32-bit, wraps modulo 2^32 with no flag):
- ch_rd_update: SRC += BLK*4.
- ch_wr_update: DST += 4 if STRIDE = 0, DST += 32 if STRIDE = 1.
- Updates apply in any state.

Priority rules:
- A bus write to SRC or DST in the same cycle as an update pulse: the bus write wins and the update is dropped.
- ch_done in the same cycle as a W1C of DONE: DONE stays 1 (set wins).
- START and STOP both written in one access: STOP wins and no start pulse is issued.

irq = OR over channels of (DONE & IE).

## Timing
Reset values:
- hrdata = 0, hready_out = 1, hresp = OKAY.
- ch_start, ch_stop = 0; ch_src, ch_dst, ch_blk = 0.
- irq = 0.
- All channels IDLE; DONE = 0, STRIDE = 0, IE = 1.

Bus timing:
- OKAY transfers run with zero wait states.
- ERROR (ERR_EN = 1), two cycles:
  - cycle 1: hready_out = 0, hresp = 01.
  - cycle 2: hready_out = 1, hresp = 01.
  - The illegal write is discarded; the illegal read returns 0.
- With ERR_EN = 0, illegal accesses complete as OKAY with no side effect.
- Back-to-back transfers are supported: a write data phase may overlap the next address phase.

Channel and interrupt latencies:
- ch_start and ch_stop are registered: they pulse 1 cycle after the data phase completes.
- BUSY reads 1 starting with the first access whose data phase follows the ch_start cycle.
- irq rises 1 cycle after ch_done (DONE is registered, irq is combinational from it).

Reset mid-operation (hreset asserted at any time):
- All state returns to reset values immediately.
- Any in-flight bus transfer is abandoned.

## Test plan
- Reset values: after reset, read every register of both channels -> CTRL = 0, IE = 1, VERSION = 32'h0002_0002; irq = 0.
- Start and done: write SRC = 0x1000, BLK = 4, then START on ch1 -> ch_start[1] pulses for exactly one cycle and BUSY = 1. Two ch_rd_update pulses -> SRC = 0x1020. ch_done[1] -> DONE = 1, irq = 1. W1C STAT -> irq = 0.
- Stride and wrap-around: DST = 0xFFFF_FFF0 with STRIDE = 1, one ch_wr_update -> DST = 0x0000_0010. With STRIDE = 0 -> DST = 0xFFFF_FFF4.
- Simultaneous events: ch_done coincident with a DONE W1C -> DONE = 1. A write of SRC = 0x55 coincident with ch_rd_update -> SRC = 0x55. START while BUSY -> no ch_start pulse.
- Errors: read 0x040 with NUM_CH = 2 -> hready_out low for 1 cycle, hresp = 01 for 2 cycles, hrdata = 0. A halfword write to SRC -> ERROR and SRC unchanged. With ERR_EN = 0, the same accesses complete OKAY with no effect.
- Stop and reset: STOP while BUSY -> ch_stop pulses, BUSY = 0, DONE = 0, SRC retained. Assert hreset during a write data phase -> all reset values, no stale write applied.
